// File: rtl/capture_sequencer_if.sv
// Sample-path / capture-FIFO write-port bundle between the ADC stream and the capture FIFO.
// A write transfers when wr_en is high at a rising clk edge; the sequencer only raises
// wr_en when sample_valid is high and full is low in the same cycle.
interface capture_sequencer_if;
  logic sample_valid;
  logic full;
  logic empty;
  logic wr_en;

  // master: the sequencer (issues writes); slave: the ADC / FIFO side
  modport master (input sample_valid, input full, input empty, output wr_en);
  modport slave  (output sample_valid, output full, output empty, input wr_en);
endinterface

// File: rtl/capture_sequencer.sv
// Capture sequencer: writes decimated ADC samples into the capture FIFO with programmable
// length, optional continuous re-arming with hold-off, abort and status outputs.
module capture_sequencer #(
  parameter int CNT_W  = 16,
  parameter int DEC_W  = 8,
  parameter int HOLD_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode_cont,
  input  logic [CNT_W-1:0]     cap_len,
  input  logic [DEC_W-1:0]     decim,
  input  logic [HOLD_W-1:0]    holdoff,
  capture_sequencer_if.master  sif,
  output logic [3:0]           state,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [15:0]          capture_cnt,
  output logic                 done,
  output logic                 truncated
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_CAPTURE = 4'b0010,
    S_DRAIN   = 4'b0100,
    S_HOLD    = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cap_len_l;
  logic [DEC_W-1:0]  decim_l;
  logic              mode_cont_l;
  logic [HOLD_W-1:0] holdoff_l;
  logic [DEC_W-1:0]  dc;
  logic [DEC_W-1:0]  dec_eff;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stop_seen;

  logic wr_en_c;
  logic latch_cfg;
  logic run_clr;
  logic clr_trunc;
  logic set_trunc;
  logic set_stop;
  logic cap_done;
  logic hold_clr;

  assign dec_eff = (decim_l == '0) ? DEC_W'(1) : decim_l;

  always_comb begin
    state_d   = state_q;
    wr_en_c   = 1'b0;
    latch_cfg = 1'b0;
    run_clr   = 1'b0;
    clr_trunc = 1'b0;
    set_trunc = 1'b0;
    set_stop  = 1'b0;
    cap_done  = 1'b0;
    hold_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          // cap_len is what gets latched this edge, so a zero length is rejected here
          if (cap_len != '0) begin
            state_d   = S_CAPTURE;
            run_clr   = 1'b1;
            clr_trunc = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        wr_en_c = sif.sample_valid && (dc == '0) && !sif.full;
        if (wr_en_c && (sample_cnt == cap_len_l - CNT_W'(1))) begin
          state_d  = S_DRAIN;
          set_stop = stop;
        end else if (sif.full) begin
          state_d   = S_DRAIN;
          set_trunc = 1'b1;
        end else if (stop) begin
          state_d   = S_DRAIN;
          set_trunc = 1'b1;
          set_stop  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (sif.empty) begin
          cap_done = 1'b1;
          hold_clr = 1'b1;
          state_d  = (mode_cont_l && !stop_seen) ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if ((holdoff_l == '0) || (hold_cnt == holdoff_l - HOLD_W'(1))) begin
          state_d = S_CAPTURE;
          run_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_len_l   <= '0;
      decim_l     <= '0;
      mode_cont_l <= 1'b0;
      holdoff_l   <= '0;
      dc          <= '0;
      hold_cnt    <= '0;
      stop_seen   <= 1'b0;
      sample_cnt  <= '0;
      capture_cnt <= '0;
      done        <= 1'b0;
      truncated   <= 1'b0;
    end else begin
      done <= cap_done;
      if (latch_cfg) begin
        cap_len_l   <= cap_len;
        decim_l     <= decim;
        mode_cont_l <= mode_cont;
        holdoff_l   <= holdoff;
      end
      if (run_clr) begin
        sample_cnt <= '0;
        dc         <= '0;
      end else if (state_q == S_CAPTURE) begin
        if (wr_en_c) sample_cnt <= sample_cnt + CNT_W'(1);
        if (sif.sample_valid) dc <= (dc == dec_eff - DEC_W'(1)) ? '0 : dc + DEC_W'(1);
      end
      if (clr_trunc) truncated <= 1'b0;
      else if (set_trunc) truncated <= 1'b1;
      // stop_seen only blocks the re-arm decision in DRAIN, so it is consumed there
      if (cap_done) stop_seen <= 1'b0;
      else if (set_stop) stop_seen <= 1'b1;
      if (cap_done) capture_cnt <= capture_cnt + 16'd1;
      if (hold_clr) hold_cnt <= '0;
      else if (state_q == S_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign sif.wr_en = wr_en_c;
  assign state     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: expected write beats are queued when a capture is
// launched and compared against the writes collected by the negedge monitor.
module tb_capture_sequencer;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_CAPTURE = 4'b0010;
  localparam logic [3:0] ST_DRAIN   = 4'b0100;
  localparam logic [3:0] ST_HOLD    = 4'b1000;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        stop;
  logic        mode_cont;
  logic [15:0] cap_len;
  logic [7:0]  decim;
  logic [15:0] holdoff;
  logic [3:0]  state;
  logic [15:0] sample_cnt;
  logic [15:0] capture_cnt;
  logic        done;
  logic        truncated;

  capture_sequencer_if sif ();

  capture_sequencer dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .stop        (stop),
    .mode_cont   (mode_cont),
    .cap_len     (cap_len),
    .decim       (decim),
    .holdoff     (holdoff),
    .sif         (sif.master),
    .state       (state),
    .sample_cnt  (sample_cnt),
    .capture_cnt (capture_cnt),
    .done        (done),
    .truncated   (truncated)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] hold_q[$];
  int checks   = 0;
  int failures = 0;
  int beat_idx = 0;
  int done_cnt = 0;
  int hold_run = 0;

  // monitor: beat index of every write within the current capture, done pulses, HOLD run lengths
  always @(negedge clk) begin
    if (state !== ST_CAPTURE) begin
      beat_idx = 0;
    end else begin
      if (sif.wr_en === 1'b1) obs_q.push_back(32'(beat_idx));
      if (sif.sample_valid === 1'b1) beat_idx++;
    end
    if (done === 1'b1) done_cnt++;
    if (state === ST_HOLD) begin
      hold_run++;
    end else if (hold_run != 0) begin
      hold_q.push_back(32'(hold_run));
      hold_run = 0;
    end
  end

  // driver / checker tasks
  task automatic pclk();
    @(posedge clk);
    #1;
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      nclk();
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_writes(input int cnt, input int budget);
    int n = 0;
    while (obs_q.size() < cnt && n < budget) begin
      nclk();
      n++;
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      nclk();
      n++;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    pclk();
    start = 1'b0;
  endtask

  task automatic push_beats(input int first, input int step, input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(32'(first + i * step));
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_beat"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode_cont = 1'b0;
    cap_len = 16'd0;
    decim = 8'd1;
    holdoff = 16'd0;
    sif.sample_valid = 1'b0;
    sif.full = 1'b0;
    sif.empty = 1'b0;

    // reset values
    repeat (3) pclk();
    nclk();
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_wr_en", 32'(sif.wr_en), 32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    check("rst_capture_cnt", 32'(capture_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_truncated", 32'(truncated), 32'd0);
    pclk();
    rstn = 1'b1;
    pclk();

    // single shot, 8 samples, empty 3 cycles after the last write
    cap_len = 16'd8;
    decim = 8'd1;
    sif.sample_valid = 1'b1;
    push_beats(0, 1, 8);
    base = done_cnt;
    start_pulse();
    wait_state(ST_DRAIN, 40, "t1_drain");
    repeat (3) pclk();
    sif.empty = 1'b1;
    wait_state(ST_IDLE, 20, "t1_idle");
    check("t1_done", 32'(done), 32'd1);
    check("t1_capture_cnt", 32'(capture_cnt), 32'd1);
    check("t1_sample_cnt", 32'(sample_cnt), 32'd8);
    check("t1_truncated", 32'(truncated), 32'd0);
    compare_q("t1");
    repeat (3) nclk();
    check("t1_done_once", 32'(done_cnt - base), 32'd1);

    // decimation by 3, then decim=0 acting as 1
    pclk();
    decim = 8'd3;
    cap_len = 16'd4;
    push_beats(0, 3, 4);
    start_pulse();
    wait_state(ST_IDLE, 100, "t2_idle");
    check("t2_sample_cnt", 32'(sample_cnt), 32'd4);
    check("t2_capture_cnt", 32'(capture_cnt), 32'd2);
    compare_q("t2_dec3");
    pclk();
    decim = 8'd0;
    push_beats(0, 1, 4);
    start_pulse();
    wait_state(ST_IDLE, 100, "t2_idle0");
    check("t2_capture_cnt0", 32'(capture_cnt), 32'd3);
    compare_q("t2_dec0");

    // FIFO full after 5 writes
    pclk();
    decim = 8'd1;
    cap_len = 16'd10;
    sif.empty = 1'b0;
    push_beats(0, 1, 5);
    start_pulse();
    wait_writes(5, 100);
    pclk();
    sif.full = 1'b1;
    nclk();
    check("t3_blocked_wr", 32'(sif.wr_en), 32'd0);
    check("t3_still_capture", 32'(state), 32'(ST_CAPTURE));
    nclk();
    check("t3_drain", 32'(state), 32'(ST_DRAIN));
    check("t3_truncated", 32'(truncated), 32'd1);
    check("t3_sample_cnt", 32'(sample_cnt), 32'd5);
    compare_q("t3");
    pclk();
    sif.full = 1'b0;
    sif.empty = 1'b1;
    wait_state(ST_IDLE, 20, "t3_idle");
    check("t3_capture_cnt", 32'(capture_cnt), 32'd4);

    // continuous mode, hold-off 5, stop during HOLD
    pclk();
    mode_cont = 1'b1;
    cap_len = 16'd4;
    holdoff = 16'd5;
    hold_q.delete();
    push_beats(0, 1, 4);
    push_beats(0, 1, 4);
    base = done_cnt;
    start_pulse();
    nclk();
    check("t4_trunc_cleared", 32'(truncated), 32'd0);
    wait_dones(base + 2, 200);
    check("t4_rearm_hold", 32'(state), 32'(ST_HOLD));
    check("t4_capture_cnt", 32'(capture_cnt), 32'd6);
    pclk();
    stop = 1'b1;
    pclk();
    stop = 1'b0;
    nclk();
    check("t4_stop_idle", 32'(state), 32'(ST_IDLE));
    check("t4_hold_runs", 32'(hold_q.size()), 32'd2);
    check("t4_holdoff_len", (hold_q.size() > 0) ? hold_q[0] : 32'd0, 32'd5);
    compare_q("t4");

    // start with cap_len=0 is ignored
    pclk();
    mode_cont = 1'b0;
    cap_len = 16'd0;
    base = done_cnt;
    start = 1'b1;
    repeat (3) pclk();
    start = 1'b0;
    nclk();
    check("t5_stays_idle", 32'(state), 32'(ST_IDLE));
    repeat (3) nclk();
    check("t5_no_done", 32'(done_cnt - base), 32'd0);
    check("t5_capture_cnt", 32'(capture_cnt), 32'd6);
    compare_q("t5");

    // stop coincident with the final write: write happens, no truncation, no re-arm
    pclk();
    mode_cont = 1'b1;
    holdoff = 16'd0;
    cap_len = 16'd4;
    sif.empty = 1'b0;
    push_beats(0, 1, 4);
    start_pulse();
    wait_writes(3, 100);
    pclk();
    stop = 1'b1;
    nclk();
    check("t6_final_wr", 32'(sif.wr_en), 32'd1);
    pclk();
    stop = 1'b0;
    nclk();
    check("t6_drain", 32'(state), 32'(ST_DRAIN));
    check("t6_truncated", 32'(truncated), 32'd0);
    check("t6_sample_cnt", 32'(sample_cnt), 32'd4);
    compare_q("t6");
    base = done_cnt;
    pclk();
    sif.empty = 1'b1;
    wait_dones(base + 1, 20);
    check("t6_no_rearm", 32'(state), 32'(ST_IDLE));
    check("t6_capture_cnt", 32'(capture_cnt), 32'd7);

    // cap_len / decim changed mid-capture have no effect
    pclk();
    mode_cont = 1'b0;
    cap_len = 16'd4;
    decim = 8'd1;
    push_beats(0, 1, 4);
    start_pulse();
    cap_len = 16'd2;
    decim = 8'd4;
    pclk();
    cap_len = 16'd9;
    wait_state(ST_IDLE, 100, "t7_idle");
    check("t7_sample_cnt", 32'(sample_cnt), 32'd4);
    check("t7_capture_cnt", 32'(capture_cnt), 32'd8);
    compare_q("t7");

    // asynchronous reset between clock edges mid-capture
    pclk();
    cap_len = 16'd20;
    decim = 8'd1;
    sif.empty = 1'b0;
    start_pulse();
    wait_writes(3, 100);
    #2;
    rstn = 1'b0;
    #1;
    check("t8_state", 32'(state), 32'(ST_IDLE));
    check("t8_wr_en", 32'(sif.wr_en), 32'd0);
    check("t8_sample_cnt", 32'(sample_cnt), 32'd0);
    check("t8_capture_cnt", 32'(capture_cnt), 32'd0);
    check("t8_truncated", 32'(truncated), 32'd0);
    check("t8_done", 32'(done), 32'd0);
    base = done_cnt;
    sif.empty = 1'b1;
    repeat (3) pclk();
    rstn = 1'b1;
    repeat (5) nclk();
    check("t8_no_done", 32'(done_cnt - base), 32'd0);
    check("t8_idle_after", 32'(state), 32'(ST_IDLE));
    obs_q.delete();
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
